// File: rtl/rf_access_ctrl.sv
// Register-file write-port owner: arbitrates core writeback vs. debug access and runs the
// x1..x31 clear sequencer. Optional stall statistics are enabled with RF_ACCESS_STATS_EN.
module rf_access_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_we,
  input  logic [4:0]        core_waddr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [4:0]        dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [4:0]        rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata
`ifdef RF_ACCESS_STATS_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  localparam int unsigned StarveW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);
  localparam logic [4:0] LastReg = 5'd31;

  typedef enum logic [1:0] {
    StClear,
    StRun,
    StAck
  } state_e;

  state_e              state_q, state_d;
  logic [4:0]          clr_cnt_q, clr_cnt_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic [StarveW-1:0]  starve_core;
  logic                ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                clr_accept;
  logic                dbg_grant;
  logic                core_rf_we;
  logic [4:0]          core_rf_waddr;
  logic [DATA_W-1:0]   core_rf_wdata;

  assign rf_raddr  = dbg_addr;
  assign dbg_ack   = ack_q;
  assign dbg_rdata = rdata_q;

  assign clr_accept = (state_q == StRun) && clr_start;
  assign dbg_grant  = (state_q == StRun) && !clr_start && dbg_req &&
                      (!core_we || (starve_q == StarveMax));

  // Core path drives zeros when idle so the RF port is quiet.
  assign core_rf_we    = core_we && (core_waddr != 5'd0);
  assign core_rf_waddr = core_we ? core_waddr : 5'd0;
  assign core_rf_wdata = core_we ? core_wdata : '0;

  // Counts only cycles where debug is actually blocked by a core write.
  assign starve_core = (dbg_req && core_we) ?
                       ((starve_q == StarveMax) ? starve_q : starve_q + StarveW'(1)) : '0;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    starve_d   = starve_q;
    ack_d      = 1'b0;
    rdata_d    = rdata_q;
    rf_we      = 1'b0;
    rf_waddr   = 5'd0;
    rf_wdata   = '0;
    core_stall = 1'b0;
    clr_busy   = 1'b0;

    unique case (state_q)
      StClear: begin
        rf_we      = 1'b1;
        rf_waddr   = clr_cnt_q;
        rf_wdata   = '0;
        clr_busy   = 1'b1;
        core_stall = 1'b1;
        starve_d   = '0;
        if (clr_cnt_q == LastReg) begin
          state_d = StRun;
        end else begin
          clr_cnt_d = clr_cnt_q + 5'd1;
        end
      end

      StRun: begin
        if (dbg_grant) begin
          core_stall = core_we;
          if (dbg_wr) begin
            rf_we    = (dbg_addr != 5'd0);
            rf_waddr = dbg_addr;
            rf_wdata = dbg_wdata;
          end else begin
            rdata_d = rf_rdata;
          end
          ack_d    = 1'b1;
          starve_d = '0;
          state_d  = StAck;
        end else begin
          rf_we    = core_rf_we;
          rf_waddr = core_rf_waddr;
          rf_wdata = core_rf_wdata;
          if (clr_accept) begin
            starve_d  = '0;
            clr_cnt_d = 5'd1;
            state_d   = StClear;
          end else begin
            starve_d = starve_core;
          end
        end
      end

      StAck: begin
        // Request is still held here while the requester sees the ack; ignore it.
        rf_we    = core_rf_we;
        rf_waddr = core_rf_waddr;
        rf_wdata = core_rf_wdata;
        starve_d = '0;
        state_d  = StRun;
      end

      default: begin
        state_d = StClear;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StClear;
      clr_cnt_q <= 5'd1;
      starve_q  <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      starve_q  <= starve_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef RF_ACCESS_STATS_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else if (clr_accept) begin
      stall_cnt_q <= 16'd0;
    end else if (core_stall && core_we && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule
